// File: rtl/usb_rx_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : usb_rx_decoder_if
// Brief    : Bit-sample inputs and byte/strobe outputs of the USB RX decoder.
// Revision : 1.0
// ============================================================================
interface usb_rx_decoder_if;
    logic        sync_done;
    logic        bit_stb;
    logic        bit_dp;
    logic        bit_dn;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_active;
    logic        rx_eop;
    logic        rx_err;
    logic [1:0]  rx_err_code;
    logic [10:0] rx_byte_cnt;

    modport master (
        output sync_done, bit_stb, bit_dp, bit_dn,
        input  rx_data, rx_valid, rx_active, rx_eop, rx_err, rx_err_code, rx_byte_cnt
    );

    modport slave (
        input  sync_done, bit_stb, bit_dp, bit_dn,
        output rx_data, rx_valid, rx_active, rx_eop, rx_err, rx_err_code, rx_byte_cnt
    );
endinterface
`default_nettype wire

// File: rtl/usb_rx_decoder.sv
`default_nettype none
// ============================================================================
// Module   : usb_rx_decoder
// Brief    : Full-speed USB RX: NRZI decode, bit unstuff, byte assembly, EOP.
// Revision : 1.0
// ============================================================================
module usb_rx_decoder #(
    parameter int STUFF_LEN  = 6,
    parameter int IDLE_J_CNT = 8
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    usb_rx_decoder_if.slave bus
);
    localparam int ONES_W = $clog2(STUFF_LEN + 1);
    localparam int J_W    = (IDLE_J_CNT > 1) ? $clog2(IDLE_J_CNT) : 1;
    localparam logic [ONES_W-1:0] c_STUFF_MAX = ONES_W'(STUFF_LEN);
    localparam logic [ONES_W-1:0] c_ONE       = ONES_W'(1);
    localparam logic [J_W-1:0]    c_J_LAST    = J_W'(IDLE_J_CNT - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DATA     = 2'd1,
        S_EOP      = 2'd2,
        S_ERR_WAIT = 2'd3
    } state_t;

    state_t            r_state, w_state_n;
    logic              r_prev_level, w_prev_level_n;   // 1 = J, 0 = K
    logic [ONES_W-1:0] r_ones_cnt, w_ones_cnt_n;
    logic [2:0]        r_bit_cnt, w_bit_cnt_n;
    logic [7:0]        r_shreg, w_shreg_n;
    logic [1:0]        r_se0_cnt, w_se0_cnt_n;
    logic [J_W-1:0]    r_j_cnt, w_j_cnt_n;
    logic [7:0]        r_data, w_data_n;
    logic              r_valid, w_valid_n;
    logic              r_active, w_active_n;
    logic              r_eop, w_eop_n;
    logic              r_err, w_err_n;
    logic [1:0]        r_err_code, w_err_code_n;
    logic [10:0]       r_byte_cnt, w_byte_cnt_n;

    logic       w_start, w_fail;
    logic [1:0] w_fail_code;

    wire logic       w_j     =  bus.bit_dp & ~bus.bit_dn;
    wire logic       w_se0   = ~bus.bit_dp & ~bus.bit_dn;
    wire logic       w_se1   =  bus.bit_dp &  bus.bit_dn;
    wire logic       w_nrzi  = (bus.bit_dp == r_prev_level);
    wire logic [7:0] w_shift = {w_nrzi, r_shreg[7:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_prev_level <= 1'b0;
            r_ones_cnt   <= '0;
            r_bit_cnt    <= 3'd0;
            r_shreg      <= 8'h00;
            r_se0_cnt    <= 2'd0;
            r_j_cnt      <= '0;
            r_data       <= 8'h00;
            r_valid      <= 1'b0;
            r_active     <= 1'b0;
            r_eop        <= 1'b0;
            r_err        <= 1'b0;
            r_err_code   <= 2'd0;
            r_byte_cnt   <= 11'd0;
        end else begin
            r_state      <= w_state_n;
            r_prev_level <= w_prev_level_n;
            r_ones_cnt   <= w_ones_cnt_n;
            r_bit_cnt    <= w_bit_cnt_n;
            r_shreg      <= w_shreg_n;
            r_se0_cnt    <= w_se0_cnt_n;
            r_j_cnt      <= w_j_cnt_n;
            r_data       <= w_data_n;
            r_valid      <= w_valid_n;
            r_active     <= w_active_n;
            r_eop        <= w_eop_n;
            r_err        <= w_err_n;
            r_err_code   <= w_err_code_n;
            r_byte_cnt   <= w_byte_cnt_n;
        end
    end

    always_comb begin
        w_state_n      = r_state;
        w_prev_level_n = r_prev_level;
        w_ones_cnt_n   = r_ones_cnt;
        w_bit_cnt_n    = r_bit_cnt;
        w_shreg_n      = r_shreg;
        w_se0_cnt_n    = r_se0_cnt;
        w_j_cnt_n      = r_j_cnt;
        w_data_n       = r_data;
        w_valid_n      = 1'b0;
        w_active_n     = r_active;
        w_eop_n        = 1'b0;
        w_err_n        = 1'b0;
        w_err_code_n   = r_err_code;
        w_byte_cnt_n   = r_byte_cnt;
        w_start        = 1'b0;
        w_fail         = 1'b0;
        w_fail_code    = 2'd0;

        case (r_state)
            S_IDLE: w_start = bus.sync_done;
            S_DATA: if (bus.bit_stb) begin
                if (w_se0) begin
                    w_state_n   = S_EOP;
                    w_se0_cnt_n = 2'd1;
                end else if (w_se1) begin
                    w_fail      = 1'b1;
                    w_fail_code = 2'd3;
                end else begin
                    w_prev_level_n = bus.bit_dp;
                    // After a full run of ones the next bit must be a stuffed 0.
                    if (r_ones_cnt == c_STUFF_MAX) begin
                        if (w_nrzi) begin
                            w_fail      = 1'b1;
                            w_fail_code = 2'd1;
                        end else begin
                            w_ones_cnt_n = '0;
                        end
                    end else begin
                        w_shreg_n    = w_shift;
                        w_ones_cnt_n = w_nrzi ? (r_ones_cnt + c_ONE) : '0;
                        w_bit_cnt_n  = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_data_n  = w_shift;
                            w_valid_n = 1'b1;
                            if (r_byte_cnt != 11'h7FF)
                                w_byte_cnt_n = r_byte_cnt + 11'd1;
                        end
                    end
                end
            end
            S_EOP: if (bus.bit_stb) begin
                if (w_se0) begin
                    if (r_se0_cnt == 2'd2) begin
                        w_fail      = 1'b1;
                        w_fail_code = 2'd3;
                    end else begin
                        w_se0_cnt_n = r_se0_cnt + 2'd1;
                    end
                end else if (w_j) begin
                    w_eop_n    = 1'b1;
                    w_active_n = 1'b0;
                    w_state_n  = S_IDLE;
                    if (r_bit_cnt != 3'd0) begin
                        w_err_n      = 1'b1;
                        w_err_code_n = 2'd2;
                    end
                end else begin
                    w_fail      = 1'b1;
                    w_fail_code = 2'd3;
                end
            end
            S_ERR_WAIT: begin
                if (bus.sync_done) begin
                    w_start = 1'b1;
                end else if (bus.bit_stb) begin
                    if (!w_j) begin
                        w_j_cnt_n = '0;
                    end else if (r_j_cnt == c_J_LAST) begin
                        w_j_cnt_n = '0;
                        w_state_n = S_IDLE;
                    end else begin
                        w_j_cnt_n = r_j_cnt + J_W'(1);
                    end
                end
            end
            default: w_state_n = S_IDLE;
        endcase

        if (w_fail) begin
            w_state_n    = S_ERR_WAIT;
            w_err_n      = 1'b1;
            w_err_code_n = w_fail_code;
            w_active_n   = 1'b0;
            w_j_cnt_n    = '0;
        end

        if (w_start) begin
            w_state_n      = S_DATA;
            w_prev_level_n = 1'b0;
            w_ones_cnt_n   = '0;
            w_bit_cnt_n    = 3'd0;
            w_shreg_n      = 8'h00;
            w_byte_cnt_n   = 11'd0;
            w_active_n     = 1'b1;
        end
    end

    assign bus.rx_data     = r_data;
    assign bus.rx_valid    = r_valid;
    assign bus.rx_active   = r_active;
    assign bus.rx_eop      = r_eop;
    assign bus.rx_err      = r_err;
    assign bus.rx_err_code = r_err_code;
    assign bus.rx_byte_cnt = r_byte_cnt;
endmodule
`default_nettype wire

// File: tb/tb_usb_rx_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_rx_decoder
// Brief    : Directed scoreboard bench for usb_rx_decoder.
// Revision : 1.0
// ============================================================================
module tb_usb_rx_decoder;
    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Event word: {valid, eop, err, err_code[1:0], data[7:0]}
    logic [12:0] sb[$];
    logic        tb_level;
    int          tb_ones;
    logic        snap_valid, snap_eop, snap_err;

    usb_rx_decoder_if bus ();

    usb_rx_decoder #(
        .STUFF_LEN  (6),
        .IDLE_J_CNT (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] ev_byte(input logic [7:0] d);
        return {3'b100, 2'b00, d};
    endfunction
    function automatic logic [12:0] ev_eop();
        return {3'b010, 2'b00, 8'h00};
    endfunction
    function automatic logic [12:0] ev_err(input logic [1:0] c);
        return {3'b001, c, 8'h00};
    endfunction
    function automatic logic [12:0] ev_eop_err(input logic [1:0] c);
        return {3'b011, c, 8'h00};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [12:0] obs;
        logic [12:0] exp;
        @(posedge clk);
        #1;
        if (bus.rx_valid || bus.rx_eop || bus.rx_err) begin
            obs = {bus.rx_valid, bus.rx_eop, bus.rx_err,
                   bus.rx_err ? bus.rx_err_code : 2'd0,
                   bus.rx_valid ? bus.rx_data : 8'h00};
            exp = (sb.size() > 0) ? sb.pop_front() : 13'h1FFF;
            check("strobe_event", 32'(obs), 32'(exp));
            if (bus.rx_eop || bus.rx_err)
                check("active_at_end", 32'(bus.rx_active), 32'd0);
        end
    endtask

    task automatic send_line(input logic dp, input logic dn);
        bus.bit_stb = 1'b1;
        bus.bit_dp  = dp;
        bus.bit_dn  = dn;
        tick();
        snap_valid  = bus.rx_valid;
        snap_eop    = bus.rx_eop;
        snap_err    = bus.rx_err;
        bus.bit_stb = 1'b0;
        repeat (4) tick();
    endtask

    // NRZI encoder with bit stuffing after six consecutive ones.
    task automatic send_bit(input logic b);
        if (!b) tb_level = ~tb_level;
        send_line(tb_level, ~tb_level);
        tb_ones = b ? tb_ones + 1 : 0;
        if (tb_ones == 6) begin
            tb_level = ~tb_level;
            send_line(tb_level, ~tb_level);
            tb_ones = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] d);
        sb.push_back(ev_byte(d));
        for (int i = 0; i < 8; i++) send_bit(d[i]);
    endtask

    task automatic do_sync();
        bus.sync_done = 1'b1;
        tick();
        bus.sync_done = 1'b0;
        tick();
        tb_level = 1'b0;
        tb_ones  = 0;
    endtask

    task automatic send_eop();
        send_line(1'b0, 1'b0);
        send_line(1'b0, 1'b0);
        send_line(1'b1, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, 32'({bus.rx_data, bus.rx_valid, bus.rx_active, bus.rx_eop, bus.rx_err,
                        bus.rx_err_code, bus.rx_byte_cnt}), 32'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.sync_done = 1'b0;
        bus.bit_stb   = 1'b0;
        bus.bit_dp    = 1'b1;
        bus.bit_dn    = 1'b0;
        tb_level      = 1'b0;
        tb_ones       = 0;
        repeat (2) tick();
        check_reset_outputs("reset_values");
        rst_n = 1'b1;
        repeat (2) tick();

        // Single byte 0xC3
        do_sync();
        check("active_after_sync", 32'(bus.rx_active), 32'd1);
        send_byte(8'hC3);
        check("byte_cnt_single", 32'(bus.rx_byte_cnt), 32'd1);
        sb.push_back(ev_eop());
        send_eop();
        check("eop_latency", 32'({snap_valid, snap_eop, snap_err}), 32'b010);
        check("data_held", 32'(bus.rx_data), 32'hC3);

        // Stuffing across 0xFF, 0x01
        do_sync();
        send_byte(8'hFF);
        send_byte(8'h01);
        check("byte_cnt_stuff", 32'(bus.rx_byte_cnt), 32'd2);
        sb.push_back(ev_eop());
        send_eop();

        // Stuff error: one J (decoded 0) then 7 unchanged J levels
        do_sync();
        repeat (7) send_line(1'b1, 1'b0);
        sb.push_back(ev_err(2'd1));
        send_line(1'b1, 1'b0);
        check("stuff_err_latency", 32'({snap_valid, snap_eop, snap_err}), 32'b001);
        check("stuff_err_code", 32'(bus.rx_err_code), 32'd1);
        repeat (8) send_line(1'b1, 1'b0);

        // Alignment: byte plus 4 stray bits
        do_sync();
        send_byte(8'h2D);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        sb.push_back(ev_eop_err(2'd2));
        send_eop();
        check("align_strobes", 32'({snap_valid, snap_eop, snap_err}), 32'b011);
        check("align_code", 32'(bus.rx_err_code), 32'd2);
        check("align_byte_cnt", 32'(bus.rx_byte_cnt), 32'd1);

        // Line error: SE1 mid-byte, then three SE0 on the following packet
        do_sync();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        sb.push_back(ev_err(2'd3));
        send_line(1'b1, 1'b1);
        check("se1_code", 32'(bus.rx_err_code), 32'd3);
        do_sync();
        send_byte(8'h5A);
        send_line(1'b0, 1'b0);
        send_line(1'b0, 1'b0);
        sb.push_back(ev_err(2'd3));
        send_line(1'b0, 1'b0);
        check("se0x3_strobes", 32'({snap_valid, snap_eop, snap_err}), 32'b001);
        repeat (8) send_line(1'b1, 1'b0);

        // Reset mid-byte, then a clean packet
        do_sync();
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        rst_n = 1'b0;
        tick();
        check_reset_outputs("reset_mid_byte");
        rst_n = 1'b1;
        tick();
        do_sync();
        send_byte(8'hA5);
        sb.push_back(ev_eop());
        send_eop();
        check("post_reset_data", 32'(bus.rx_data), 32'hA5);
        check("post_reset_cnt", 32'(bus.rx_byte_cnt), 32'd1);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
